// File: rtl/tlc_pkg.sv
// tlc_pkg: TLC5957 constants, shifter state encoding and LAT placement helper
package tlc_pkg;
  localparam int GS_WORD_BITS        = 48;
  localparam int TLC_GROUPS          = 16;
  localparam int TLC_BYTES_PER_GROUP = 6;
  localparam int TLC_WRTGS_BITS      = 1;
  localparam int TLC_LATGS_BITS      = 3;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  // LAT is high for the last n bits of a word_bits-long GS word
  function automatic logic lat_on(input int idx, input int word_bits, input int n);
    return idx >= word_bits - n;
  endfunction
endpackage

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchroniser followed by a registered rising-edge pulse
//   clk     in  destination clock
//   rst_n   in  asynchronous active-low reset
//   i_d     in  asynchronous level input
//   o_pulse out one-cycle pulse, 3 clk after the input rises
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_pulse
);
  logic r_s1, r_s2, r_s3, r_p;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
      r_p  <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_p  <= r_s2 & ~r_s3;
    end
  end
  assign o_pulse = r_p;
endmodule

// File: rtl/tlc_line_shifter.sv
// tlc_line_shifter: serialises one line of GS bytes from the FIFO into the TLC5957 chain
//   sys_clk/global_rst_n   clock, async active-low reset (SCLK = sys_clk/2)
//   line_sync              asynchronous line-start level, >=2 sys_clk wide
//   fifo_rd/data/empty     FIFO read port, data valid the cycle after fifo_rd
//   tlc_sclk/sin/lat       TLC serial clock, data and latch/command line
//   busy/underrun/overrun  line in progress, sticky FIFO stall, sticky start-while-busy
import tlc_pkg::*;
module tlc_line_shifter #(
  parameter int GROUPS          = TLC_GROUPS,
  parameter int BYTES_PER_GROUP = TLC_BYTES_PER_GROUP,
  parameter int WRTGS_BITS      = TLC_WRTGS_BITS,
  parameter int LATGS_BITS      = TLC_LATGS_BITS
) (
  input  logic       sys_clk,
  input  logic       global_rst_n,
  input  logic       line_sync,
  output logic       fifo_rd,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       tlc_sclk,
  output logic       tlc_sin,
  output logic       tlc_lat,
  output logic       busy,
  output logic       underrun,
  output logic       overrun
);
  localparam int BW = BYTES_PER_GROUP > 1 ? $clog2(BYTES_PER_GROUP) : 1;
  localparam int GW = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam int WB = BYTES_PER_GROUP * 8;
  state_t         r_state;
  logic           r_ph, r_rd, r_rd_q, r_hold_v;
  logic           r_sclk, r_sin, r_lat, r_busy, r_underrun, r_overrun;
  logic [2:0]     r_bit;
  logic [BW-1:0]  r_byte;
  logic [GW-1:0]  r_grp;
  logic [7:0]     r_sr, r_hold;
  logic           w_start, w_byte_end, w_last_byte, w_last_grp, w_line_end, w_pf, w_ld_issue;
  logic           w_lat_bit, w_lat_byte, w_lat_load;
  logic [BW-1:0]  w_nbyte;
  logic [GW-1:0]  w_ngrp;
  logic [7:0]     w_next;
  sync_edge u_sync (.clk(sys_clk), .rst_n(global_rst_n), .i_d(line_sync), .o_pulse(w_start));
  assign w_byte_end  = r_state == SHIFT && r_ph && r_bit == 3'd7;
  assign w_last_byte = r_byte == BW'(BYTES_PER_GROUP - 1);
  assign w_last_grp  = r_grp == GW'(GROUPS - 1);
  assign w_line_end  = w_byte_end && w_last_byte && w_last_grp;
  assign w_nbyte     = w_last_byte ? '0 : r_byte + 1'b1;
  assign w_ngrp      = w_last_byte ? r_grp + 1'b1 : r_grp;
  assign w_next      = r_hold_v ? r_hold : fifo_data;
  assign w_lat_bit   = lat_on(int'(r_byte) * 8 + int'(r_bit) + 1, WB, w_last_grp ? LATGS_BITS : WRTGS_BITS);
  assign w_lat_byte  = lat_on(int'(w_nbyte) * 8, WB, w_ngrp == GW'(GROUPS - 1) ? LATGS_BITS : WRTGS_BITS);
  assign w_lat_load  = lat_on(int'(r_byte) * 8, WB, w_last_grp ? LATGS_BITS : WRTGS_BITS);
  // one read in flight at a time; no prefetch beyond the last byte of the line
  assign w_pf        = r_state == SHIFT && r_bit >= 3'd5 && !r_hold_v && !r_rd && !r_rd_q && !fifo_empty &&
                       !(w_last_byte && w_last_grp);
  assign w_ld_issue  = r_state == LOAD && !r_rd && !r_rd_q && !fifo_empty;
  always_ff @(posedge sys_clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_state    <= IDLE;
      r_ph       <= 1'b0;
      r_rd       <= 1'b0;
      r_rd_q     <= 1'b0;
      r_hold_v   <= 1'b0;
      r_hold     <= '0;
      r_sr       <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_grp      <= '0;
      r_sclk     <= 1'b0;
      r_sin      <= 1'b0;
      r_lat      <= 1'b0;
      r_busy     <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_rd   <= w_pf || w_ld_issue;
      r_rd_q <= r_rd;
      if (w_start && r_state != IDLE && !w_line_end) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (w_start) begin
          r_state  <= LOAD;
          r_busy   <= 1'b1;
          r_bit    <= '0;
          r_byte   <= '0;
          r_grp    <= '0;
          r_hold_v <= 1'b0;
        end
        LOAD: if (r_rd_q) begin
          r_sr    <= fifo_data;
          r_sin   <= fifo_data[7];
          r_lat   <= w_lat_load;
          r_ph    <= 1'b0;
          r_state <= SHIFT;
        end else if (fifo_empty && !r_rd) r_underrun <= 1'b1;
        SHIFT: begin
          if (r_rd_q && !w_byte_end) begin
            r_hold   <= fifo_data;
            r_hold_v <= 1'b1;
          end
          r_ph   <= ~r_ph;
          r_sclk <= ~r_ph;
          if (r_ph) begin
            if (r_bit != 3'd7) begin
              r_bit <= r_bit + 1'b1;
              r_sr  <= r_sr << 1;
              r_sin <= r_sr[6];
              r_lat <= w_lat_bit;
            end else if (w_line_end) begin
              r_sin    <= 1'b0;
              r_lat    <= 1'b0;
              r_bit    <= '0;
              r_byte   <= '0;
              r_grp    <= '0;
              r_hold_v <= 1'b0;
              r_state  <= w_start ? LOAD : IDLE;
              r_busy   <= w_start;
            end else begin
              r_bit  <= '0;
              r_byte <= w_nbyte;
              r_grp  <= w_ngrp;
              if (r_hold_v || r_rd_q) begin
                r_sr     <= w_next;
                r_sin    <= w_next[7];
                r_lat    <= w_lat_byte;
                r_hold_v <= 1'b0;
              end else begin
                r_state    <= LOAD;
                r_lat      <= 1'b0;
                r_underrun <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign fifo_rd  = r_rd;
  assign tlc_sclk = r_sclk;
  assign tlc_sin  = r_sin;
  assign tlc_lat  = r_lat;
  assign busy     = r_busy;
  assign underrun = r_underrun;
  assign overrun  = r_overrun;
endmodule

// File: tb/tb_tlc_line_shifter.sv
// tb_tlc_line_shifter: directed bench for tlc_line_shifter (16-group and 2-group builds)
module tb_tlc_line_shifter;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic ls1 = 1'b0, ls2 = 1'b0, sel = 1'b0, mon_clr = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic rd1, rd2, sclk1, sclk2, sin1, sin2, lat1, lat2, busy1, busy2, ur1, ur2, or1, or2;
  logic [7:0] mem [0:1023];
  int rp = 0, wp = 0, n_chk = 0, n_err = 0;
  int n_sclk = 0, gaps = 0, unstable = 0, cyc = 0, last_rise = 0;
  logic p_sclk = 1'b0, p_sin = 1'b0, p_lat = 1'b0;
  logic sin_b [0:2047];
  logic lat_b [0:2047];
  wire m_empty = rp >= wp;
  wire m_rd    = sel ? rd2 : rd1;
  wire m_sclk  = sel ? sclk2 : sclk1;
  wire m_sin   = sel ? sin2 : sin1;
  wire m_lat   = sel ? lat2 : lat1;
  wire m_busy  = sel ? busy2 : busy1;
  wire m_ur    = sel ? ur2 : ur1;
  wire m_or    = sel ? or2 : or1;
  wire e1      = sel ? 1'b1 : m_empty;
  wire e2      = sel ? m_empty : 1'b1;

  always #5 sys_clk = ~sys_clk;

  tlc_line_shifter u_dut (
    .sys_clk(sys_clk), .global_rst_n(rst_n), .line_sync(ls1), .fifo_rd(rd1), .fifo_data(fifo_data),
    .fifo_empty(e1), .tlc_sclk(sclk1), .tlc_sin(sin1), .tlc_lat(lat1), .busy(busy1),
    .underrun(ur1), .overrun(or1));

  tlc_line_shifter #(.GROUPS(2)) u_dut2 (
    .sys_clk(sys_clk), .global_rst_n(rst_n), .line_sync(ls2), .fifo_rd(rd2), .fifo_data(fifo_data),
    .fifo_empty(e2), .tlc_sclk(sclk2), .tlc_sin(sin2), .tlc_lat(lat2), .busy(busy2),
    .underrun(ur2), .overrun(or2));

  always @(posedge sys_clk) if (m_rd && rp < wp) begin
    fifo_data <= mem[rp];
    rp <= rp + 1;
  end

  always @(negedge sys_clk) begin
    if (mon_clr) begin
      n_sclk = 0; gaps = 0; unstable = 0; cyc = 0; last_rise = 0;
      p_sclk = m_sclk; p_sin = m_sin; p_lat = m_lat;
    end else begin
      cyc++;
      if (m_sclk && !p_sclk) begin
        if (n_sclk > 0 && cyc - last_rise != 2) gaps++;
        last_rise = cyc;
        if (n_sclk < 2048) begin
          sin_b[n_sclk] = m_sin;
          lat_b[n_sclk] = m_lat;
        end
        n_sclk++;
      end
      if ((m_sin != p_sin || m_lat != p_lat) && m_sclk) unstable++;
      p_sclk = m_sclk; p_sin = m_sin; p_lat = m_lat;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp++;
  endtask

  task automatic clear_mon();
    @(posedge sys_clk); mon_clr = 1'b1;
    @(posedge sys_clk); mon_clr = 1'b0;
  endtask

  task automatic start_line(input logic which);
    @(negedge sys_clk);
    if (which) ls2 = 1'b1; else ls1 = 1'b1;
    repeat (2) @(negedge sys_clk);
    ls1 = 1'b0; ls2 = 1'b0;
  endtask

  task automatic wait_sclk(input string tag, input int n);
    int i = 0;
    while (n_sclk < n && i < 5000) begin @(negedge sys_clk); i++; end
    chk({tag, "_reach_sclk"}, int'(n_sclk >= n), 1);
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    while (!m_busy && i < 20) begin @(negedge sys_clk); i++; end
    chk({tag, "_busy_rise"}, int'(m_busy), 1);
    i = 0;
    while (m_busy && i < 5000) begin @(negedge sys_clk); i++; end
    chk({tag, "_busy_fall"}, int'(m_busy), 0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic chk_line(input string tag, input int s, input int groups, input int exp_n, input int exp_hi);
    int bad_sin = 0, bad_lat = 0, hi = 0, g, p;
    logic eb, el;
    for (int n = 0; n < exp_n; n++) begin
      eb = mem[s + n / 8][7 - n % 8];
      g = n / 48; p = n % 48;
      el = (g == groups - 1) ? (p >= 45) : (p == 47);
      if (sin_b[n] !== eb) bad_sin++;
      if (lat_b[n] !== el) bad_lat++;
      if (lat_b[n] === 1'b1) hi++;
    end
    chk({tag, "_sclk_count"}, n_sclk, exp_n);
    chk({tag, "_sin_bad"}, bad_sin, 0);
    chk({tag, "_lat_bad"}, bad_lat, 0);
    chk({tag, "_lat_high"}, hi, exp_hi);
    chk({tag, "_bytes_read"}, rp - s, exp_n / 8);
    chk({tag, "_unstable"}, unstable, 0);
    chk({tag, "_idle_pins"}, int'({m_sclk, m_sin, m_lat}), 0);
  endtask

  initial begin
    int s, t;
    repeat (3) @(negedge sys_clk);
    chk("rst_sclk", int'(sclk1), 0);
    chk("rst_sin", int'(sin1), 0);
    chk("rst_lat", int'(lat1), 0);
    chk("rst_busy", int'(busy1), 0);
    chk("rst_fifo_rd", int'(rd1), 0);
    chk("rst_flags", int'({ur1, or1}), 0);
    rst_n = 1'b1;
    s = rp;
    for (int k = 0; k < 96; k++) push(8'(k));
    clear_mon(); start_line(1'b0); wait_done("t1");
    chk_line("t1", s, 16, 768, 18);
    chk("t1_gaps", gaps, 0);
    chk("t1_fifo_empty", int'(m_empty), 1);
    chk("t1_flags", int'({m_ur, m_or}), 0);
    s = rp;
    for (int k = 0; k < 10; k++) push(8'(k * 7 + 3));
    clear_mon(); start_line(1'b0);
    t = 0;
    while (rp < s + 10 && t < 2000) begin @(negedge sys_clk); t++; end
    chk("t2_reach_byte10", int'(rp >= s + 10), 1);
    repeat (40) @(negedge sys_clk);
    for (int k = 10; k < 96; k++) push(8'(k * 7 + 3));
    wait_done("t2");
    chk_line("t2", s, 16, 768, 18);
    chk("t2_gap_seen", int'(gaps > 0), 1);
    chk("t2_underrun", int'(m_ur), 1);
    s = rp;
    for (int k = 0; k < 96; k++) push(8'(255 - k));
    clear_mon(); start_line(1'b0);
    wait_sclk("t3", 500);
    start_line(1'b0);
    wait_done("t3");
    chk_line("t3", s, 16, 768, 18);
    chk("t3_overrun", int'(m_or), 1);
    repeat (20) @(negedge sys_clk);
    chk("t3_no_restart", int'({m_busy, m_sclk}), 0);
    for (int k = 0; k < 96; k++) push(8'(k + 16));
    clear_mon(); start_line(1'b0);
    wait_sclk("t4", 300);
    @(negedge sys_clk); rst_n = 1'b0;
    #1;
    chk("t4_rst_pins", int'({sclk1, sin1, lat1}), 0);
    chk("t4_rst_busy_rd", int'({busy1, rd1}), 0);
    chk("t4_rst_flags", int'({ur1, or1}), 0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    s = rp;
    t = wp - rp;
    for (int k = t; k < 96; k++) push(8'(k * 3));
    clear_mon(); start_line(1'b0); wait_done("t4");
    chk_line("t4", s, 16, 768, 18);
    chk("t4_flags", int'({m_ur, m_or}), 0);
    s = rp;
    for (int k = 0; k < 96; k++) push(k % 2 == 0 ? 8'hFF : 8'h00);
    clear_mon(); start_line(1'b0); wait_done("t5");
    chk_line("t5", s, 16, 768, 18);
    t = 0;
    for (int n = 1; n < 768; n++) if (sin_b[n] !== sin_b[n - 1]) t++;
    chk("t5_toggles", t, 95);
    chk("t5_gaps", gaps, 0);
    sel = 1'b1;
    s = rp;
    for (int k = 0; k < 12; k++) push(8'(k * 17 + 5));
    clear_mon(); start_line(1'b1); wait_done("t6");
    chk_line("t6", s, 2, 96, 4);
    chk("t6_gaps", gaps, 0);
    chk("t6_flags", int'({m_ur, m_or}), 0);
    sel = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
